// File: rtl/btb_pkg.sv
// Shared branch-type encodings and direction-counter helpers for the
// n-way branch target buffer.
package btb_pkg;

    typedef enum logic [2:0] {
        TYPE_FORMAL = 3'd0,
        TYPE_BRANCH = 3'd1,
        TYPE_CALL   = 3'd2,
        TYPE_RET    = 3'd3,
        TYPE_JUMP   = 3'd4
    } btb_type_e;

    // Fresh entries start just on the resolved side of the taken threshold.
    function automatic int unsigned cnt_init(input logic taken, input int unsigned cnt_w);
        int unsigned half;
        half = 32'd1 << (cnt_w - 1);
        return taken ? half : half - 1;
    endfunction

    function automatic int unsigned cnt_step(input int unsigned cnt, input logic up,
                                             input int unsigned cnt_w);
        int unsigned max_v;
        max_v = (32'd1 << cnt_w) - 1;
        if (up) begin
            return (cnt == max_v) ? cnt : cnt + 1;
        end
        return (cnt == 0) ? cnt : cnt - 1;
    endfunction

endpackage

// File: rtl/btb_nway_if.sv
// Lookup, update and response signal bundle of the branch target buffer.
interface btb_nway_if #(
    parameter int ADDR_W = 32,
    parameter int WAY_W  = 2
);
    import btb_pkg::*;

    logic              LookupValid;
    logic [ADDR_W-1:0] LookupPc;
    logic              UpValid;
    logic [ADDR_W-1:0] UpPc;
    logic [ADDR_W-1:0] UpTarget;
    logic [2:0]        UpType;
    logic              UpTaken;
    logic              Flush;
    logic              RespValid;
    logic              RespHit;
    logic [WAY_W-1:0]  RespWay;
    logic [ADDR_W-1:0] RespNextPc;
    logic [2:0]        RespType;
    logic              RespTaken;

    modport master (
        output LookupValid, LookupPc, UpValid, UpPc, UpTarget, UpType, UpTaken, Flush,
        input  RespValid, RespHit, RespWay, RespNextPc, RespType, RespTaken
    );

    modport slave (
        input  LookupValid, LookupPc, UpValid, UpPc, UpTarget, UpType, UpTaken, Flush,
        output RespValid, RespHit, RespWay, RespNextPc, RespType, RespTaken
    );

endinterface

// File: rtl/btb_lru_age.sv
// True-LRU age update for one set: the touched way becomes youngest and
// every younger way ages by one; the oldest way is offered as victim.
module btb_lru_age
    import btb_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int WAY_W = 2
) (
    input  logic [WAYS-1:0][WAY_W-1:0] age_in,
    input  logic [WAY_W-1:0]           touch_way,
    output logic [WAYS-1:0][WAY_W-1:0] age_out,
    output logic [WAY_W-1:0]           victim_way
);

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touch_way) begin
                age_out[w] = '0;
            end else if (age_in[w] < age_in[touch_way]) begin
                age_out[w] = age_in[w] + 1'b1;
            end else begin
                age_out[w] = age_in[w];
            end
        end
    end

    always_comb begin
        victim_way = '0;
        for (int w = 1; w < WAYS; w++) begin
            if (age_in[w] > age_in[victim_way]) begin
                victim_way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/btb_nway.sv
// Set-associative branch target buffer with registered one-cycle lookup,
// saturating direction counters and true-LRU replacement.
module btb_nway
    import btb_pkg::*;
#(
    parameter int SETS     = 256,
    parameter int WAYS     = 4,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5,
    parameter int CNT_W    = 2
) (
    input logic      Clk,
    input logic      Rest,
    btb_nway_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

    function automatic logic [WAYS-1:0][WAY_W-1:0] init_ages();
        for (int w = 0; w < WAYS; w++) init_ages[w] = WAY_W'(w);
    endfunction
    localparam logic [WAYS-1:0][WAY_W-1:0] AGE_INIT = init_ages();

    logic [WAYS-1:0]            valid_q  [SETS];
    logic [WAYS-1:0]            valid_d  [SETS];
    logic [TAG_W-1:0]           tag_q    [SETS][WAYS];
    logic [TAG_W-1:0]           tag_d    [SETS][WAYS];
    logic [2:0]                 type_q   [SETS][WAYS];
    logic [2:0]                 type_d   [SETS][WAYS];
    logic [ADDR_W-1:0]          target_q [SETS][WAYS];
    logic [ADDR_W-1:0]          target_d [SETS][WAYS];
    logic [CNT_W-1:0]           cnt_q    [SETS][WAYS];
    logic [CNT_W-1:0]           cnt_d    [SETS][WAYS];
    logic [WAYS-1:0][WAY_W-1:0] age_q    [SETS];
    logic [WAYS-1:0][WAY_W-1:0] age_d    [SETS];

    logic              resp_valid_q, resp_valid_d;
    logic              resp_hit_q, resp_hit_d;
    logic [WAY_W-1:0]  resp_way_q, resp_way_d;
    logic [ADDR_W-1:0] resp_next_pc_q, resp_next_pc_d;
    logic [2:0]        resp_type_q, resp_type_d;
    logic              resp_taken_q, resp_taken_d;

    logic [IDX_W-1:0]           l_idx, u_idx;
    logic [TAG_W-1:0]           l_tag, u_tag;
    logic                       l_hit, l_taken, u_hit, u_has_free;
    logic [WAY_W-1:0]           l_way, u_hit_way, u_free_way, u_way, u_victim, l_victim;
    logic [ADDR_W-1:0]          seq_pc;
    logic [WAYS-1:0][WAY_W-1:0] l_age_next, u_age_next;
    logic                       unused_bits;

    assign l_idx = bus.LookupPc[OFFSET_W +: IDX_W];
    assign l_tag = bus.LookupPc[ADDR_W-1 -: TAG_W];
    assign u_idx = bus.UpPc[OFFSET_W +: IDX_W];
    assign u_tag = bus.UpPc[ADDR_W-1 -: TAG_W];

    // Descending scan so the lowest matching / lowest free way wins.
    always_comb begin
        l_hit      = 1'b0;
        l_way      = '0;
        u_hit      = 1'b0;
        u_hit_way  = '0;
        u_has_free = 1'b0;
        u_free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
                l_hit = 1'b1;
                l_way = WAY_W'(w);
            end
            if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
                u_hit     = 1'b1;
                u_hit_way = WAY_W'(w);
            end
            if (!valid_q[u_idx][w]) begin
                u_has_free = 1'b1;
                u_free_way = WAY_W'(w);
            end
        end
    end

    assign u_way   = u_hit ? u_hit_way : (u_has_free ? u_free_way : u_victim);
    assign l_taken = l_hit && (type_q[l_idx][l_way] != TYPE_BRANCH || cnt_q[l_idx][l_way][CNT_W-1]);
    assign seq_pc  = {bus.LookupPc[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}} + (ADDR_W'(1) << OFFSET_W);

    btb_lru_age #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru_lookup (
        .age_in(age_q[l_idx]), .touch_way(l_way), .age_out(l_age_next), .victim_way(l_victim)
    );

    btb_lru_age #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru_update (
        .age_in(age_q[u_idx]), .touch_way(u_way), .age_out(u_age_next), .victim_way(u_victim)
    );

    // Update's age touch is applied last so it overrides a same-set lookup touch.
    always_comb begin
        valid_d        = valid_q;
        tag_d          = tag_q;
        type_d         = type_q;
        target_d       = target_q;
        cnt_d          = cnt_q;
        age_d          = age_q;
        resp_valid_d   = 1'b0;
        resp_hit_d     = 1'b0;
        resp_way_d     = '0;
        resp_next_pc_d = '0;
        resp_type_d    = TYPE_FORMAL;
        resp_taken_d   = 1'b0;
        if (bus.LookupValid) begin
            resp_valid_d   = 1'b1;
            resp_hit_d     = l_hit;
            resp_way_d     = l_hit ? l_way : '0;
            resp_type_d    = l_hit ? type_q[l_idx][l_way] : TYPE_FORMAL;
            resp_taken_d   = l_taken;
            resp_next_pc_d = l_taken ? target_q[l_idx][l_way] : seq_pc;
            if (l_hit) age_d[l_idx] = l_age_next;
        end
        if (bus.Flush) begin
            valid_d = '{default: '0};
        end else if (bus.UpValid) begin
            valid_d[u_idx][u_way]  = 1'b1;
            tag_d[u_idx][u_way]    = u_tag;
            type_d[u_idx][u_way]   = bus.UpType;
            target_d[u_idx][u_way] = bus.UpTarget;
            cnt_d[u_idx][u_way]    = u_hit
                ? CNT_W'(cnt_step(32'(cnt_q[u_idx][u_way]), bus.UpTaken, CNT_W))
                : CNT_W'(cnt_init(bus.UpTaken, CNT_W));
            age_d[u_idx]           = u_age_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rest) begin
            valid_q        <= '{default: '0};
            cnt_q          <= '{default: '{default: '0}};
            age_q          <= '{default: AGE_INIT};
            resp_valid_q   <= 1'b0;
            resp_hit_q     <= 1'b0;
            resp_way_q     <= '0;
            resp_next_pc_q <= '0;
            resp_type_q    <= '0;
            resp_taken_q   <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            cnt_q          <= cnt_d;
            age_q          <= age_d;
            resp_valid_q   <= resp_valid_d;
            resp_hit_q     <= resp_hit_d;
            resp_way_q     <= resp_way_d;
            resp_next_pc_q <= resp_next_pc_d;
            resp_type_q    <= resp_type_d;
            resp_taken_q   <= resp_taken_d;
        end
    end

    // Payload fields are qualified by valid, so they need no reset.
    always_ff @(posedge Clk) begin
        tag_q    <= tag_d;
        type_q   <= type_d;
        target_q <= target_d;
    end

    assign bus.RespValid  = resp_valid_q;
    assign bus.RespHit    = resp_hit_q;
    assign bus.RespWay    = resp_way_q;
    assign bus.RespNextPc = resp_next_pc_q;
    assign bus.RespType   = resp_type_q;
    assign bus.RespTaken  = resp_taken_q;

    assign unused_bits = ^{bus.LookupPc[OFFSET_W-1:0], bus.UpPc[OFFSET_W-1:0], l_victim};

endmodule

// File: tb/tb_btb_nway.sv
// Scoreboard bench for btb_nway: a recency-list reference model predicts each
// cycle's response, and a monitor compares it one cycle later.
module tb_btb_nway;
    import btb_pkg::*;

    localparam int SETS     = 256;
    localparam int WAYS     = 4;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int CNT_W    = 2;
    localparam int IDX_W    = 8;
    localparam int WAY_W    = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int CNT_HALF = 1 << (CNT_W - 1);

    typedef struct packed {
        logic              valid;
        logic              hit;
        logic [WAY_W-1:0]  way;
        logic [ADDR_W-1:0] next_pc;
        logic [2:0]        rtype;
        logic              taken;
    } resp_t;

    logic clk = 1'b0;
    logic rest;

    btb_nway_if #(.ADDR_W(ADDR_W), .WAY_W(WAY_W)) bus ();

    btb_nway #(
        .SETS(SETS), .WAYS(WAYS), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)
    ) dut (
        .Clk(clk), .Rest(rest), .bus(bus)
    );

    always #5 clk = ~clk;

    bit          m_valid  [SETS][WAYS];
    logic [31:0] m_tag    [SETS][WAYS];
    logic [31:0] m_target [SETS][WAYS];
    logic [2:0]  m_type   [SETS][WAYS];
    int          m_cnt    [SETS][WAYS];
    int          m_order  [SETS][$];
    resp_t       exp_q    [$];
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc >> OFFSET_W) % SETS);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (OFFSET_W + IDX_W);
    endfunction

    function automatic int find_way(input int s, input logic [31:0] t);
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_order[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                m_order[s].push_back(w);
                m_valid[s][w] = 1'b0;
                m_cnt[s][w]   = 0;
            end
        end
    endtask

    // Most recently used way sits at the front; the back is the LRU victim.
    task automatic touch(input int s, input int w);
        for (int i = 0; i < m_order[s].size(); i++) begin
            if (m_order[s][i] == w) begin
                m_order[s].delete(i);
                break;
            end
        end
        m_order[s].push_front(w);
    endtask

    task automatic apply_stimulus(input logic rst_n, input logic lv, input logic [31:0] lpc,
                                  input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                                  input logic [2:0] utype, input logic utaken, input logic flush);
        resp_t e;
        int ls, us, lw, uw;
        @(negedge clk);
        #1;
        rest            = rst_n;
        bus.LookupValid = lv;
        bus.LookupPc    = lpc;
        bus.UpValid     = uv;
        bus.UpPc        = upc;
        bus.UpTarget    = utgt;
        bus.UpType      = utype;
        bus.UpTaken     = utaken;
        bus.Flush       = flush;
        e = '0;
        if (!rst_n) begin
            model_reset();
            exp_q.push_back(e);
            return;
        end
        ls = set_of(lpc);
        us = set_of(upc);
        lw = find_way(ls, tag_of(lpc));
        if (lv) begin
            e.valid   = 1'b1;
            e.next_pc = ((lpc >> OFFSET_W) << OFFSET_W) + 32'(1 << OFFSET_W);
            if (lw >= 0) begin
                e.hit   = 1'b1;
                e.way   = WAY_W'(lw);
                e.rtype = m_type[ls][lw];
                e.taken = (m_type[ls][lw] != TYPE_BRANCH) || (m_cnt[ls][lw] >= CNT_HALF);
                if (e.taken) e.next_pc = m_target[ls][lw];
            end
        end
        uw = -1;
        if (uv && !flush) begin
            uw = find_way(us, tag_of(upc));
            if (uw >= 0) begin
                if (utaken) m_cnt[us][uw] = (m_cnt[us][uw] < CNT_MAX) ? m_cnt[us][uw] + 1 : CNT_MAX;
                else        m_cnt[us][uw] = (m_cnt[us][uw] > 0) ? m_cnt[us][uw] - 1 : 0;
            end else begin
                for (int w = WAYS - 1; w >= 0; w--) begin
                    if (!m_valid[us][w]) uw = w;
                end
                if (uw < 0) uw = m_order[us][$];
                m_cnt[us][uw] = utaken ? CNT_HALF : CNT_HALF - 1;
            end
            m_valid[us][uw]  = 1'b1;
            m_tag[us][uw]    = tag_of(upc);
            m_type[us][uw]   = utype;
            m_target[us][uw] = utgt;
        end
        if (lv && lw >= 0 && !(uw >= 0 && us == ls)) touch(ls, lw);
        if (uw >= 0) touch(us, uw);
        if (flush) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    task automatic check_output(input resp_t e);
        resp_t a;
        a = {bus.RespValid, bus.RespHit, bus.RespWay, bus.RespNextPc, bus.RespType, bus.RespTaken};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL resp#%0d: got v=%0b hit=%0b way=%0d pc=%h type=%0d tk=%0b, expected v=%0b hit=%0b way=%0d pc=%h type=%0d tk=%0b",
                     vectors, a.valid, a.hit, a.way, a.next_pc, a.rtype, a.taken,
                     e.valid, e.hit, e.way, e.next_pc, e.rtype, e.taken);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                check_output(exp_q.pop_front());
            end else if (bus.RespValid === 1'b1) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_resp: got RespValid=1, expected 0");
            end
        end
    end

    task automatic drv_reset();  apply_stimulus(1'b0, 1'b0, 0, 1'b0, 0, 0, 3'd0, 1'b0, 1'b0); endtask
    task automatic drv_flush();  apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 0, 3'd0, 1'b0, 1'b1); endtask
    task automatic drv_lookup(input logic [31:0] pc);
        apply_stimulus(1'b1, 1'b1, pc, 1'b0, 0, 0, 3'd0, 1'b0, 1'b0);
    endtask
    task automatic drv_update(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] t,
                              input logic tk);
        apply_stimulus(1'b1, 1'b0, 0, 1'b1, pc, tgt, t, tk, 1'b0);
    endtask

    logic [31:0] fill_pcs [5]  = '{32'h1000, 32'h3000, 32'h5000, 32'h7000, 32'h9000};
    logic [31:0] tag_pool [6]  = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h7FFFF};
    int          set_pool [2]  = '{3, 255};

    function automatic logic [31:0] rand_pc();
        logic [31:0] t;
        int s;
        t = tag_pool[$urandom_range(0, 5)];
        s = set_pool[$urandom_range(0, 1)];
        return (t << (OFFSET_W + IDX_W)) | (32'(s) << OFFSET_W) | 32'($urandom_range(0, 31));
    endfunction

    initial begin
        rest = 1'b0;
        bus.LookupValid = 1'b0; bus.LookupPc = '0; bus.UpValid = 1'b0; bus.UpPc = '0;
        bus.UpTarget = '0; bus.UpType = '0; bus.UpTaken = 1'b0; bus.Flush = 1'b0;
        drv_reset();
        drv_reset();
        drv_lookup(32'h1000);

        drv_update(32'h1000, 32'h2000, TYPE_BRANCH, 1'b1);
        drv_lookup(32'h1000);
        drv_update(32'h1000, 32'h2000, TYPE_BRANCH, 1'b0);
        drv_update(32'h1000, 32'h2000, TYPE_BRANCH, 1'b0);
        drv_lookup(32'h1000);
        repeat (3) drv_update(32'h1000, 32'h2000, TYPE_BRANCH, 1'b1);
        drv_lookup(32'h1000);

        drv_flush();
        for (int i = 0; i < 5; i++) drv_update(fill_pcs[i], fill_pcs[i] + 32'h100, TYPE_JUMP, 1'b1);
        for (int i = 0; i < 5; i++) drv_lookup(fill_pcs[i]);

        drv_flush();
        for (int i = 0; i < 4; i++) drv_update(fill_pcs[i], fill_pcs[i] + 32'h40, TYPE_CALL, 1'b1);
        drv_lookup(32'h1000);
        drv_update(32'h9000, 32'h9400, TYPE_RET, 1'b0);
        for (int i = 0; i < 5; i++) drv_lookup(fill_pcs[i]);

        apply_stimulus(1'b1, 1'b0, 0, 1'b1, 32'h1000, 32'h2000, TYPE_BRANCH, 1'b1, 1'b1);
        drv_lookup(32'h1000);
        drv_lookup(32'h3000);

        drv_update(32'h1000, 32'h2000, TYPE_JUMP, 1'b1);
        drv_lookup(32'h1000);
        drv_reset();
        drv_lookup(32'h1000);
        drv_lookup(32'hFFFF_FFF7);

        for (int n = 0; n < 800; n++) begin
            apply_stimulus(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 9) < 7), rand_pc(),
                           1'($urandom_range(0, 1)), rand_pc(), $urandom(),
                           3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 49) == 0));
        end
        drv_lookup(32'h0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
